// File: rtl/mul_div_sequencer.sv
// Iterative unsigned multiply/divide sequencer.
// A single shared add/sub/pass stage is driven once per cycle; a multiply yields a
// 2*WIDTH-bit product and a divide yields quotient/remainder, each over WIDTH iterations.
module mul_div_sequencer #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ITER_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp_start,
  input  logic             inp_op,
  input  logic [WIDTH-1:0] inp_a,
  input  logic [WIDTH-1:0] inp_b,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic             out_div_by_zero,
  output logic [1:0]       out_addsub_ctrl
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  localparam logic [1:0]        CtrlPass = 2'd0;
  localparam logic [1:0]        CtrlAdd  = 2'd1;
  localparam logic [1:0]        CtrlSub  = 2'd2;
  localparam logic [ITER_W-1:0] LastIter = ITER_W'(WIDTH - 1);

  state_e              state_q;
  logic [WIDTH-1:0]    hi_q;
  logic [WIDTH-1:0]    lo_q;
  logic [WIDTH-1:0]    operand_q;  // multiplicand or divisor
  logic [ITER_W-1:0]   count_q;
  logic                dbz_q;

  logic [1:0]          ctrl;
  logic [WIDTH:0]      stage_x;
  logic [WIDTH:0]      stage_y;
  logic [WIDTH:0]      stage_res;

  // Control code for the shared stage: add on a set multiplier bit, subtract while dividing.
  always_comb begin
    ctrl = CtrlPass;
    case (state_q)
      StMul:   ctrl = lo_q[0] ? CtrlAdd : CtrlPass;
      StDiv:   ctrl = CtrlSub;
      default: ctrl = CtrlPass;
    endcase
  end

  // Stage operands: divide shifts the next dividend bit into the partial remainder.
  always_comb begin
    stage_x = {1'b0, hi_q};
    stage_y = {1'b0, operand_q};
    if (state_q == StDiv) begin
      stage_x = {hi_q, lo_q[WIDTH-1]};
    end
  end

  // Shared WIDTH+1 bit add/sub/pass stage; bit WIDTH is carry (add) or borrow (sub).
  always_comb begin
    case (ctrl)
      CtrlAdd: stage_res = stage_x + stage_y;
      CtrlSub: stage_res = stage_x - stage_y;
      default: stage_res = stage_x;
    endcase
  end

  // Sequencer FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      hi_q      <= '0;
      lo_q      <= '0;
      operand_q <= '0;
      count_q   <= '0;
      dbz_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (inp_start) begin
            count_q <= '0;
            dbz_q   <= 1'b0;
            if (!inp_op) begin
              operand_q <= inp_a;
              hi_q      <= '0;
              lo_q      <= inp_b;
              state_q   <= StMul;
            end else if (inp_b == '0) begin
              hi_q    <= inp_a;
              lo_q    <= '1;
              dbz_q   <= 1'b1;
              state_q <= StDone;
            end else begin
              operand_q <= inp_b;
              hi_q      <= '0;
              lo_q      <= inp_a;
              state_q   <= StDiv;
            end
          end
        end
        StMul: begin
          // Carry is kept: {hi,lo} <= {carry, sum, lo >> 1}.
          hi_q    <= stage_res[WIDTH:1];
          lo_q    <= {stage_res[0], lo_q[WIDTH-1:1]};
          count_q <= count_q + ITER_W'(1);
          if (count_q == LastIter) begin
            state_q <= StDone;
          end
        end
        StDiv: begin
          // Restoring step: keep the difference only if it did not borrow.
          if (!stage_res[WIDTH]) begin
            hi_q <= stage_res[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_q <= stage_x[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], 1'b0};
          end
          count_q <= count_q + ITER_W'(1);
          if (count_q == LastIter) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign out_busy        = (state_q != StIdle);
  assign out_done        = (state_q == StDone);
  assign out_hi          = hi_q;
  assign out_lo          = lo_q;
  assign out_div_by_zero = dbz_q;
  assign out_addsub_ctrl = ctrl;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Self-checking bench for mul_div_sequencer with a plain-arithmetic reference model.
module tb_mul_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        inp_start;
  logic        inp_op;
  logic [31:0] inp_a;
  logic [31:0] inp_b;
  logic        out_busy;
  logic        out_done;
  logic [31:0] out_hi;
  logic [31:0] out_lo;
  logic        out_div_by_zero;
  logic [1:0]  out_addsub_ctrl;

  int assertions = 0;
  int failures   = 0;

  mul_div_sequencer #(
    .WIDTH  (32),
    .ITER_W (6)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .inp_start       (inp_start),
    .inp_op          (inp_op),
    .inp_a           (inp_a),
    .inp_b           (inp_b),
    .out_busy        (out_busy),
    .out_done        (out_done),
    .out_hi          (out_hi),
    .out_lo          (out_lo),
    .out_div_by_zero (out_div_by_zero),
    .out_addsub_ctrl (out_addsub_ctrl)
  );

  always #5 clk = ~clk;

  // Runs one operation starting at edge 0 and checks every cycle up to one past done.
  // With extra=1, ignored start pulses with different inputs are driven in cycles 5 and 33.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input logic top,
                        input bit extra, input string name);
    logic [63:0] prod;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
    int          exp_done;
    logic [3:0]  exp_vec;
    logic [3:0]  got_vec;
    logic [64:0] exp_res;
    logic [64:0] got_res;

    if (!top) begin
      prod    = 64'(ta) * 64'(tbv);
      exp_hi  = prod[63:32];
      exp_lo  = prod[31:0];
      exp_dbz = 1'b0;
    end else if (tbv == 32'd0) begin
      exp_hi  = ta;
      exp_lo  = 32'hFFFF_FFFF;
      exp_dbz = 1'b1;
    end else begin
      exp_hi  = ta % tbv;
      exp_lo  = ta / tbv;
      exp_dbz = 1'b0;
    end
    exp_done = exp_dbz ? 1 : 33;
    exp_res  = {exp_hi, exp_lo, exp_dbz};

    @(negedge clk);
    inp_a     = ta;
    inp_b     = tbv;
    inp_op    = top;
    inp_start = 1'b1;
    @(posedge clk);
    #1;
    inp_start = 1'b0;
    // Inputs are scrambled after accept; they must not matter.
    inp_a  = $urandom;
    inp_b  = $urandom;
    inp_op = 1'($urandom_range(0, 1));

    for (int cyc = 1; cyc <= exp_done + 1; cyc++) begin
      @(negedge clk);
      if (cyc < exp_done) begin
        exp_vec = {1'b1, 1'b0, (top ? 2'd2 : (tbv[cyc-1] ? 2'd1 : 2'd0))};
      end else if (cyc == exp_done) begin
        exp_vec = 4'b1100;
      end else begin
        exp_vec = 4'b0000;
      end
      got_vec = {out_busy, out_done, out_addsub_ctrl};
      assertions++;
      if (got_vec !== exp_vec) begin
        failures++;
        $display("FAIL %s cycle %0d busy/done/ctrl: got %b expected %b", name, cyc, got_vec,
                 exp_vec);
      end
      if (cyc >= exp_done) begin
        got_res = {out_hi, out_lo, out_div_by_zero};
        assertions++;
        if (got_res !== exp_res) begin
          failures++;
          $display("FAIL %s cycle %0d hi/lo/dbz: got %h/%h/%b expected %h/%h/%b", name, cyc,
                   out_hi, out_lo, out_div_by_zero, exp_hi, exp_lo, exp_dbz);
        end
      end
      if (extra) begin
        inp_start = (cyc == 5 || cyc == 33);
        inp_op    = 1'b1;
        inp_a     = 32'd1000;
        inp_b     = 32'd3;
      end
    end
    inp_start = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    inp_start = 1'b0;
    inp_op    = 1'b0;
    inp_a     = '0;
    inp_b     = '0;
    #12;
    assertions++;
    if ({out_busy, out_done, out_hi, out_lo, out_div_by_zero, out_addsub_ctrl} !== 68'd0) begin
      failures++;
      $display("FAIL reset outputs: got busy=%b done=%b hi=%h lo=%h dbz=%b ctrl=%0d expected 0",
               out_busy, out_done, out_hi, out_lo, out_div_by_zero, out_addsub_ctrl);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(32'd7, 32'd6, 1'b0, 1'b0, "mul_7x6");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "mul_max");
    run_op(32'd100, 32'd7, 1'b1, 1'b0, "div_100_7");
    run_op(32'd12345, 32'd0, 1'b1, 1'b0, "div_by_zero");
    run_op(32'd10, 32'd3, 1'b1, 1'b0, "div_10_3_after_dbz");
  endtask

  task automatic test_ignored_start();
    run_op(32'd9, 32'd9, 1'b0, 1'b1, "mul_9x9_ignored_starts");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    inp_a     = 32'hDEAD_BEEF;
    inp_b     = 32'd13;
    inp_op    = 1'b1;
    inp_start = 1'b1;
    @(posedge clk);
    #1;
    inp_start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    assertions++;
    if ({out_busy, out_done, out_hi, out_lo, out_div_by_zero, out_addsub_ctrl} !== 68'd0) begin
      failures++;
      $display("FAIL async_reset outputs: got busy=%b done=%b hi=%h lo=%h dbz=%b ctrl=%0d exp 0",
               out_busy, out_done, out_hi, out_lo, out_div_by_zero, out_addsub_ctrl);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(32'd123456, 32'd789, 1'b0, 1'b0, "mul_after_reset");
  endtask

  task automatic test_random();
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rop;
    for (int i = 0; i < 12; i++) begin
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      rop = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) ra = 32'($urandom_range(0, 255));
      run_op(ra, rb, rop, 1'b0, $sformatf("random_%0d", i));
    end
  endtask

  // Consecutive run_op calls start again right after the IDLE return cycle.
  task automatic test_back_to_back();
    run_op(32'h8000_0000, 32'd2, 1'b0, 1'b0, "b2b_mul");
    run_op(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, "b2b_div_by_1");
    run_op(32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, "b2b_div_small");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
